// File: rtl/acc_sched_pkg.sv
// Shared types, default sizing and the accumulate helper for acc_rr_sched.
// Optional macro ACC_SAT_EN: when defined the accumulate add saturates instead of wrapping.
package acc_sched_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

    localparam int DEF_NCH      = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_DUMP_LEN = 4;

    localparam int DEF_IDX_W = $clog2(DEF_NCH);
    localparam int DEF_CNT_W = $clog2(DEF_DUMP_LEN + 1);

    // Operands must already fit in w bits; a carry out of bit w-1 means overflow.
    function automatic logic [31:0] acc_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
`ifdef ACC_SAT_EN
        if (sum > lim) sum = lim;
`else
        sum = sum & lim;
`endif
        return sum[31:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_any
);

    always_comb begin
        int c;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        c       = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(ptr) + i) % NCH;
            if (!gnt_any && req[c]) begin
                gnt_any = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/acc_rr_sched.sv
// Round-robin time-shared accumulator with integrate-and-dump and flush drain.
// Optional macro ACC_SAT_EN selects saturating accumulation (see acc_sched_pkg).
module acc_rr_sched
    import acc_sched_pkg::*;
#(
    parameter  int NCH      = DEF_NCH,
    parameter  int W        = DEF_W,
    parameter  int DUMP_LEN = DEF_DUMP_LEN,
    localparam int IW       = $clog2(NCH),
    localparam int CW       = $clog2(DUMP_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_valid,
    input  logic [NCH*W-1:0] req_data,
    output logic [NCH-1:0] req_ready,
    input  logic           flush,
    output logic           flush_busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IW-1:0]  out_ch,
    output logic [W-1:0]   out_sum,
    output logic [CW-1:0]  out_cnt
);

    // state | meaning
    // RUN   | granting samples round-robin, auto-dump at DUMP_LEN
    // FLUSH | scanning channels 0..NCH-1, emitting any partial sums
    sched_state_t state, state_nxt;

    logic [IW-1:0] ptr;
    logic [IW-1:0] scan;
    logic [W-1:0]  acc [NCH];
    logic [CW-1:0] cnt [NCH];

    logic [NCH-1:0] gnt;
    logic [IW-1:0]  g;
    logic           gnt_any;
    logic           out_free;
    logic           grant_en;
    logic           accept;
    logic [W-1:0]   sum_g;
    logic [CW:0]    cnt_inc;
    logic           dump;
    logic           scan_last;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (g),
        .gnt_any (gnt_any)
    );

    assign out_free  = !out_valid || out_ready;
    assign grant_en  = (state == RUN) && out_free && !flush;
    assign accept    = grant_en && gnt_any;
    assign req_ready = grant_en ? gnt : '0;
    assign scan_last = (scan == IW'(NCH - 1));

    assign sum_g   = W'(acc_add(32'(acc[g]), 32'(req_data[int'(g)*W +: W]), W));
    assign cnt_inc = {1'b0, cnt[g]} + (CW+1)'(1);
    assign dump    = (cnt_inc == (CW+1)'(DUMP_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = FLUSH;
            FLUSH:   if (out_free && scan_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            scan       <= '0;
            flush_busy <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sum    <= '0;
            out_cnt    <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            // A drained result is dropped here; a reload below wins in the same cycle.
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) begin
                        scan       <= '0;
                        flush_busy <= 1'b1;
                    end else if (accept) begin
                        ptr <= (g == IW'(NCH - 1)) ? '0 : g + IW'(1);
                        if (dump) begin
                            out_sum   <= sum_g;
                            out_ch    <= g;
                            out_cnt   <= CW'(DUMP_LEN);
                            out_valid <= 1'b1;
                            acc[g]    <= '0;
                            cnt[g]    <= '0;
                        end else begin
                            acc[g] <= sum_g;
                            cnt[g] <= cnt_inc[CW-1:0];
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        if (cnt[scan] != '0) begin
                            out_sum   <= acc[scan];
                            out_cnt   <= cnt[scan];
                            out_ch    <= scan;
                            out_valid <= 1'b1;
                            acc[scan] <= '0;
                            cnt[scan] <= '0;
                        end
                        if (scan_last) flush_busy <= 1'b0;
                        else           scan       <= scan + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_rr_sched.sv
// Scoreboard bench for acc_rr_sched: results queued at stimulus time, checked on each output transfer.
module tb_acc_rr_sched;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int DL  = 4;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   req_valid;
    logic [NCH*W-1:0] req_data;
    logic [NCH-1:0]   req_ready;
    logic             flush;
    logic             flush_busy;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_ch;
    logic [W-1:0]     out_sum;
    logic [2:0]       out_cnt;

    typedef struct {
        int ch;
        int sum;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    acc_rr_sched #(.NCH(NCH), .W(W), .DUMP_LEN(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .flush      (flush),
        .flush_busy (flush_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_sum    (out_sum),
        .out_cnt    (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: got ch=%0d sum=%0d cnt=%0d, required no output",
                         out_ch, out_sum, out_cnt);
            end else begin
                mon_e = sb.pop_front();
                if (out_ch !== 2'(mon_e.ch) || out_sum !== 8'(mon_e.sum) || out_cnt !== 3'(mon_e.cnt)) begin
                    n_bad++;
                    $display("FAIL out_xfer: got ch=%0d sum=%0d cnt=%0d, required ch=%0d sum=%0d cnt=%0d",
                             out_ch, out_sum, out_cnt, mon_e.ch, mon_e.sum, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_ch !== 2'd0 || out_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%0b sum=%0d ch=%0d cnt=%0d, required all 0",
                     out_valid, out_sum, out_ch, out_cnt);
        end
        n_cmp++;
        if (flush_busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got busy=%0b rdy=%b, required busy=0 rdy=0000", flush_busy, req_ready);
        end
        rst_n = 1'b1;
        next_cyc();
    endtask

    task automatic test_fairness(input int dval);
        logic [3:0] expg;
        req_data  = {4{8'(dval)}};
        req_valid = 4'hf;
        for (int i = 0; i < 16; i++) begin
            if (i >= 12) sb.push_back('{i % 4, 4 * dval, 4});
            expg = 4'(1 << (i % 4));
            @(negedge clk);
            n_cmp++;
            if (req_ready !== expg) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got rdy=%b, required %b", i, req_ready, expg);
            end
            next_cyc();
        end
        req_valid = '0;
        @(negedge clk);
        next_cyc();
    endtask

    task automatic test_single;
        int vals[4] = '{10, 20, 30, 40};
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            req_data[7:0] = 8'(vals[k]);
            if (k == 3) sb.push_back('{0, 100, 4});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0001) begin
                n_bad++;
                $display("FAIL single_grant[%0d]: got rdy=%b, required 0001", k, req_ready);
            end
            next_cyc();
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: got out_valid=%0b, required 1", out_valid);
        end
        next_cyc();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain: got out_valid=%0b, required 0", out_valid);
        end
        next_cyc();
    endtask

    task automatic test_wrap;
        int vals[4] = '{200, 100, 0, 0};
        int exp_sum;
`ifdef ACC_SAT_EN
        exp_sum = 255;
`else
        exp_sum = 44;
`endif
        out_ready = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            req_data[15:8] = 8'(vals[k]);
            if (k == 3) sb.push_back('{1, exp_sum, 4});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0010) begin
                n_bad++;
                $display("FAIL wrap_grant[%0d]: got rdy=%b, required 0010", k, req_ready);
            end
            next_cyc();
        end
        req_valid = '0;
        @(negedge clk);
        next_cyc();
    endtask

    task automatic test_backpressure;
        out_ready       = 1'b0;
        req_valid       = 4'b0100;
        req_data[23:16] = 8'd3;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sb.push_back('{2, 12, 4});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_bad++;
                $display("FAIL bp_fill[%0d]: got rdy=%b, required 0100", k, req_ready);
            end
            next_cyc();
        end
        req_data[23:16] = 8'd5;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_block[%0d]: got rdy=%b, required 0000", j, req_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_sum !== 8'd12 || out_ch !== 2'd2 || out_cnt !== 3'd4) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%0b sum=%0d ch=%0d cnt=%0d, required v=1 sum=12 ch=2 cnt=4",
                         j, out_valid, out_sum, out_ch, out_cnt);
            end
            next_cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sb.push_back('{2, 20, 4});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_bad++;
                $display("FAIL bp_resume[%0d]: got rdy=%b, required 0100", k, req_ready);
            end
            next_cyc();
        end
        req_valid = '0;
        @(negedge clk);
        next_cyc();
    endtask

    task automatic run_flush(input logic [3:0] ov_pat, input logic [3:0] rr_after);
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000 || flush_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_entry: got rdy=%b busy=%0b, required rdy=0000 busy=0", req_ready, flush_busy);
        end
        next_cyc();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (flush_busy !== 1'b1 || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL flush_busy[%0d]: got busy=%0b rdy=%b, required busy=1 rdy=0000",
                         c, flush_busy, req_ready);
            end
            n_cmp++;
            if (out_valid !== ov_pat[c]) begin
                n_bad++;
                $display("FAIL flush_ov[%0d]: got out_valid=%0b, required %0b", c, out_valid, ov_pat[c]);
            end
            next_cyc();
            flush = (c == 0);
        end
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (flush_busy !== 1'b0 || req_ready !== rr_after) begin
            n_bad++;
            $display("FAIL flush_exit: got busy=%0b rdy=%b, required busy=0 rdy=%b",
                     flush_busy, req_ready, rr_after);
        end
        next_cyc();
    endtask

    task automatic test_flush;
        out_ready     = 1'b1;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'd5;
        next_cyc();
        req_data[7:0] = 8'd6;
        next_cyc();
        req_valid       = 4'b0100;
        req_data[23:16] = 8'd7;
        next_cyc();
        req_valid      = 4'b0010;
        req_data[15:8] = 8'd9;
        sb.push_back('{0, 11, 2});
        sb.push_back('{2, 7, 1});
        run_flush(4'b1010, 4'b0010);
        req_valid = '0;
        sb.push_back('{1, 9, 1});
        run_flush(4'b0100, 4'b0000);
        run_flush(4'b0000, 4'b0000);
    endtask

    task automatic test_async_reset;
        out_ready       = 1'b0;
        req_valid       = 4'b1000;
        req_data[31:24] = 8'd4;
        next_cyc();
        req_valid     = 4'b0001;
        req_data[7:0] = 8'd3;
        next_cyc();
        req_valid = '0;
        flush     = 1'b1;
        next_cyc();
        flush = 1'b0;
        next_cyc();
        @(negedge clk);
        n_cmp++;
        if (flush_busy !== 1'b1 || out_valid !== 1'b1 || out_ch !== 2'd0 || out_sum !== 8'd3 || out_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL arst_setup: got busy=%0b v=%0b ch=%0d sum=%0d cnt=%0d, required 1 1 0 3 1",
                     flush_busy, out_valid, out_ch, out_sum, out_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_ch !== 2'd0 || out_cnt !== 3'd0
            || flush_busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL arst_now: got v=%0b sum=%0d ch=%0d cnt=%0d busy=%0b rdy=%b, required all 0",
                     out_valid, out_sum, out_ch, out_cnt, flush_busy, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        out_ready = 1'b1;
        test_fairness(2);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fairness(1);
        test_single();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
